// File: rtl/vending_pkg.sv
// Shared types and constants for the vending controller.
package vending_pkg;

  typedef enum logic {
    IDLE     = 1'b0,
    DISPENSE = 1'b1
  } state_e;

  localparam int unsigned CREDIT_W = 8;

  // One bit wider than credit so a sum never wraps before saturation.
  localparam logic [CREDIT_W:0] NICKEL_VALUE = (CREDIT_W + 1)'(5);
  localparam logic [CREDIT_W:0] DIME_VALUE   = (CREDIT_W + 1)'(10);

  function automatic logic [CREDIT_W-1:0] sat_credit(input logic [CREDIT_W:0] sum);
    return sum[CREDIT_W] ? '1 : sum[CREDIT_W-1:0];
  endfunction

endpackage

// File: rtl/vm_open_timer.sv
// Loadable down-counter; o_done flags that the door hold period has elapsed.
module vm_open_timer #(
  parameter int unsigned Width = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [Width-1:0] i_load_val,
  input  logic             i_dec,
  output logic             o_done
);

  logic [Width-1:0] r_count;
  logic [Width-1:0] w_count_d;

  always_comb begin
    w_count_d = r_count;
    if (i_load) begin
      w_count_d = i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      w_count_d = r_count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_d;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/vending_machine.sv
// Coin-accumulating vend controller: credit adder/comparator, two-state FSM and
// a registered door-open output held for OPEN_CYCLES cycles per vend.
module vending_machine
  import vending_pkg::*;
#(
  parameter int unsigned PRICE       = 15,
  parameter int unsigned OPEN_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic N,
  input  logic D,
  output logic open
);

  localparam int unsigned TimerW = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
  localparam logic [TimerW-1:0] HoldLoad = TimerW'(OPEN_CYCLES - 1);
  localparam logic [CREDIT_W:0] PriceW = PRICE[CREDIT_W:0];

  state_e              r_state;
  state_e              w_state_d;
  logic [CREDIT_W-1:0] r_credit;
  logic [CREDIT_W-1:0] w_credit_d;
  logic [CREDIT_W:0]   w_add;
  logic [CREDIT_W:0]   w_sum;
  logic                w_load;
  logic                w_dec;
  logic                w_done;
  logic                r_open;
  logic                w_open_d;

  assign w_add = (N ? NICKEL_VALUE : '0) + (D ? DIME_VALUE : '0);
  assign w_sum = {1'b0, r_credit} + w_add;

  vm_open_timer #(
    .Width (TimerW)
  ) u_open_timer (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (HoldLoad),
    .i_dec      (w_dec),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_credit <= '0;
      r_open   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_credit <= w_credit_d;
      r_open   <= w_open_d;
    end
  end

  // Coins sampled while dispensing are discarded; overpayment is not carried.
  always_comb begin
    w_state_d  = r_state;
    w_credit_d = r_credit;
    w_load     = 1'b0;
    w_dec      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_sum >= PriceW) begin
          w_state_d  = DISPENSE;
          w_credit_d = '0;
          w_load     = 1'b1;
        end else begin
          w_credit_d = sat_credit(w_sum);
        end
      end
      DISPENSE: begin
        w_credit_d = '0;
        if (w_done) begin
          w_state_d = IDLE;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: begin
        w_state_d  = IDLE;
        w_credit_d = '0;
      end
    endcase
  end

  always_comb begin
    w_open_d = (w_state_d == DISPENSE);
  end

  assign open = r_open;

endmodule

// File: tb/tb_vending_machine.sv
// Directed vector bench for vending_machine: default build plus a PRICE=25,
// OPEN_CYCLES=1 build sharing clock and reset.
module tb_vending_machine;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic n0 = 1'b0, d0 = 1'b0, n1 = 1'b0, d1 = 1'b0;
  logic open0, open1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit sel;
    bit n;
    bit d;
    bit exp_open;
  } vec_t;

  vec_t vecs[80];
  int   nv = 0;

  always #5 clk = ~clk;

  vending_machine u_dut0 (
    .clk   (clk),
    .reset (reset),
    .N     (n0),
    .D     (d0),
    .open  (open0)
  );

  vending_machine #(
    .PRICE       (25),
    .OPEN_CYCLES (1)
  ) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .N     (n1),
    .D     (d1),
    .open  (open1)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: open=%0b expected %0b", name, act, exp);
    end
  endtask

  task automatic push(input bit sel, input bit n, input bit d, input bit e);
    vecs[nv] = '{sel: sel, n: n, d: d, exp_open: e};
    nv++;
  endtask

  task automatic apply(input bit sel, input bit n, input bit d, input bit e, input string name);
    @(negedge clk);
    n0 = sel ? 1'b0 : n;
    d0 = sel ? 1'b0 : d;
    n1 = sel ? n : 1'b0;
    d1 = sel ? d : 1'b0;
    @(posedge clk);
    #1;
    check(name, sel ? open1 : open0, e);
  endtask

  initial begin
    // Default build, PRICE 15 / OPEN_CYCLES 4.
    push(0, 1, 0, 0); push(0, 0, 1, 1);                      // 5+10
    push(0, 0, 0, 1); push(0, 0, 0, 1); push(0, 0, 0, 1);
    push(0, 1, 0, 0);                                        // coin on leaving edge dropped
    push(0, 1, 0, 0); push(0, 1, 0, 0); push(0, 1, 0, 1);    // 5+5+5
    push(0, 1, 1, 1); push(0, 0, 1, 1); push(0, 1, 0, 1);    // coins while open
    push(0, 0, 0, 0);
    push(0, 0, 1, 0); push(0, 1, 0, 1);                      // 10+5
    push(0, 0, 0, 1); push(0, 0, 0, 1); push(0, 0, 0, 1);
    push(0, 0, 0, 0);
    push(0, 0, 1, 0); push(0, 0, 1, 1);                      // 10+10 overpay
    push(0, 0, 0, 1); push(0, 0, 0, 1); push(0, 0, 0, 1);
    push(0, 0, 0, 0);
    push(0, 1, 0, 0); push(0, 1, 0, 0); push(0, 0, 0, 0);    // no residual from overpay
    push(0, 1, 0, 1);
    push(0, 0, 0, 1); push(0, 0, 0, 1); push(0, 0, 0, 1);
    push(0, 0, 0, 0);
    push(0, 1, 1, 1);                                        // N+D same edge
    push(0, 0, 0, 1); push(0, 0, 0, 1); push(0, 0, 0, 1);
    push(0, 0, 0, 0);
    push(0, 0, 1, 0); push(0, 1, 0, 1);                      // first idle edge counts
    push(0, 0, 0, 1); push(0, 0, 0, 1); push(0, 0, 0, 1);
    push(0, 0, 0, 0);
    // PRICE 25 / OPEN_CYCLES 1 build.
    push(1, 0, 1, 0); push(1, 0, 1, 0); push(1, 1, 0, 1);
    push(1, 0, 0, 0);
    push(1, 0, 1, 0); push(1, 0, 1, 0); push(1, 0, 0, 0); push(1, 0, 0, 0);
    push(1, 1, 0, 1); push(1, 0, 0, 0);

    #1;
    check("reset_open0", open0, 1'b0);
    check("reset_open1", open1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < nv; i++) begin
      apply(vecs[i].sel, vecs[i].n, vecs[i].d, vecs[i].exp_open, $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a vend.
    apply(0, 1, 1, 1, "mid_vend_open");
    @(negedge clk);
    n0 = 1'b0;
    d0 = 1'b0;
    #2 reset = 1'b0;
    #1 check("async_rst_dispense", open0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    apply(0, 1, 0, 0, "post_rst_n1");
    apply(0, 1, 0, 0, "post_rst_n2");

    // Reset with 10c credit held; three nickels needed afterwards.
    @(negedge clk);
    n0 = 1'b0;
    #2 reset = 1'b0;
    #1 check("async_rst_credit", open0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    apply(0, 1, 0, 0, "cleared_n1");
    apply(0, 1, 0, 0, "cleared_n2");
    apply(0, 1, 0, 1, "cleared_n3");
    apply(0, 0, 0, 1, "cleared_hold1");
    apply(0, 0, 0, 1, "cleared_hold2");
    apply(0, 0, 0, 1, "cleared_hold3");
    apply(0, 0, 0, 0, "cleared_close");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
